mmio_out_port: RTL and testbench

- Downstream consumer of the CPU store bus: snoops mem_we / mem_data_addr / mem_write_data at the top level.
- Stores to OUT_ADDR are captured into a show-ahead FIFO and drained over a valid/ready stream, e.g. to a console, UART or bench scoreboard.
- A store to HALT_ADDR latches a sticky halt flag and exit code, so the bench can end simulation.
- Passive: never drives the memory bus and never stalls the CPU.

---
 rtl/mmio_out_port.sv | 120 ++++++++++++
 tb/tb_mmio_out_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_out_port.sv
// Passive MMIO output port: snoops CPU stores into a show-ahead FIFO drained over valid/ready,
// plus a sticky halt/exit-code register. Optional FIFO clear port enabled by MMIO_OUT_CLR_EN.
module mmio_out_port #(
  parameter logic [31:0] OUT_ADDR  = 32'h0000_FF00,
  parameter logic [31:0] HALT_ADDR = 32'h0000_FF04,
`ifdef MMIO_OUT_CLR_EN
  parameter logic [31:0] CLR_ADDR  = 32'h0000_FF08,
`endif
  parameter int unsigned DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_we,
  input  logic [31:0]              mem_data_addr,
  input  logic [31:0]              mem_write_data,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count,
  output logic                     halt,
  output logic [31:0]              halt_code
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          halt_q, halt_d;
  logic [DW-1:0] code_q, code_d;

  logic pop_c, hit_out_c, push_c, drop_c, clr_c;

`ifdef MMIO_OUT_CLR_EN
  assign clr_c = mem_we && (mem_data_addr == CLR_ADDR);
`else
  assign clr_c = 1'b0;
`endif

  // Store decode and FIFO handshake qualification
  always_comb begin
    pop_c     = valid_q && out_ready;
    hit_out_c = mem_we && (mem_data_addr == OUT_ADDR) && !halt_q;
    push_c    = hit_out_c && ((level_q < LW'(DEPTH)) || pop_c);
    drop_c    = hit_out_c && !push_c;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    halt_d   = halt_q;
    code_d   = code_q;
    if (clr_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push_c) - LW'(pop_c);
      if (drop_c && (drop_q != '1)) drop_d = drop_q + CW'(1);
    end
    if (mem_we && (mem_data_addr == HALT_ADDR) && !halt_q) begin
      halt_d = 1'b1;
      code_d = mem_write_data;
    end
    valid_d = (level_d != '0);
    // Head register looks ahead: a word written into the slot about to become head bypasses memory
    if (clr_c)
      out_data_d = '0;
    else if (push_c && (wr_ptr_q == rd_ptr_d))
      out_data_d = mem_write_data;
    else
      out_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= mem_write_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      valid_q    <= 1'b0;
      out_data_q <= '0;
      halt_q     <= 1'b0;
      code_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      out_data_q <= out_data_d;
      halt_q     <= halt_d;
      code_q     <= code_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = valid_q;
  assign level      = level_q;
  assign drop_count = drop_q;
  assign halt       = halt_q;
  assign halt_code  = code_q;

endmodule

// File: tb/tb_mmio_out_port.sv
// Self-checking bench for mmio_out_port: directed scenarios plus random traffic against a queue model.
module tb_mmio_out_port;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] OUT_A  = 32'h0000_FF00;
  localparam logic [31:0] HALT_A = 32'h0000_FF04;
  localparam logic [31:0] CLR_A  = 32'h0000_FF08;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_data_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  level;
  logic [15:0] drop_count;
  logic        halt;
  logic [31:0] halt_code;

  int checks = 0;
  int passes = 0;

  logic [31:0] mq[$];
  int unsigned m_drop = 0;
  bit          m_halt = 0;
  logic [31:0] m_code = '0;

  mmio_out_port dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_data_addr(mem_data_addr),
    .mem_write_data(mem_write_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .drop_count(drop_count),
    .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Advance the reference model by one clock using the current inputs, then move to the next falling edge
  task automatic cycle();
    bit pop;
    bit clr;
    logic [31:0] dummy;
    if (!rst) begin
      mq.delete();
      m_drop = 0;
      m_halt = 0;
      m_code = '0;
    end else begin
      pop = (mq.size() != 0) && out_ready;
      clr = 0;
`ifdef MMIO_OUT_CLR_EN
      clr = mem_we && (mem_data_addr == CLR_A);
`endif
      if (clr) begin
        mq.delete();
        m_drop = 0;
      end else begin
        if (pop) dummy = mq.pop_front();
        if (mem_we && mem_data_addr == OUT_A && !m_halt) begin
          if (mq.size() < DEPTH) mq.push_back(mem_write_data);
          else if (m_drop < 65535) m_drop++;
        end
      end
      if (mem_we && mem_data_addr == HALT_A && !m_halt) begin
        m_halt = 1;
        m_code = mem_write_data;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
    mem_we = we;
    mem_data_addr = a;
    mem_write_data = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1, a, d);
    cycle();
    drive(0, '0, '0);
  endtask

  task automatic apply_reset();
    rst = 0;
    repeat (3) begin
      drive(1'($urandom_range(0, 1)), OUT_A, $urandom);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drive(0, '0, '0);
    out_ready = 0;
    rst = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", out_data); else passes++;
    checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", level); else passes++;
    checks++; if ({halt, halt_code, drop_count} !== '0)
      $display("FAIL reset_halt_drop: got halt=%b code=%h drop=%0d expected all 0", halt, halt_code, drop_count);
    else passes++;
    store(OUT_A, 32'h41);
    checks++; if ({out_valid, out_data, level} !== {1'b1, 32'h41, 4'd1})
      $display("FAIL first_push: got v=%b d=%h lvl=%0d expected v=1 d=41 lvl=1", out_valid, out_data, level);
    else passes++;
    store(OUT_A, 32'h42);
    rst = 0;
    #1;
    checks++; if ({out_valid, level} !== {1'b0, 4'd0})
      $display("FAIL async_reset: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, level);
    else passes++;
    cycle();
    rst = 1;
  endtask

  task automatic test_order();
    apply_reset();
    for (int k = 1; k <= 3; k++) begin
      store(OUT_A, 32'(k));
      checks++; if (out_data !== 32'h1) $display("FAIL order_hold: got %h expected 1", out_data); else passes++;
    end
    checks++; if (level !== 4'd3) $display("FAIL order_level: got %0d expected 3", level); else passes++;
    out_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      checks++; if ({out_valid, out_data} !== {1'b1, 32'(k)})
        $display("FAIL order_stream: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, 32'(k));
      else passes++;
      cycle();
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL order_empty: got %b expected 0", out_valid); else passes++;
    out_ready = 0;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 1; k <= 10; k++) store(OUT_A, 32'(k));
    checks++; if (level !== 4'd8) $display("FAIL ovf_level: got %0d expected 8", level); else passes++;
    checks++; if (drop_count !== 16'd2) $display("FAIL ovf_drop: got %0d expected 2", drop_count); else passes++;
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if ({out_valid, out_data} !== {1'b1, 32'(k)})
        $display("FAIL ovf_drain: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, 32'(k));
      else passes++;
      cycle();
    end
    checks++; if ({out_valid, drop_count} !== {1'b0, 16'd2})
      $display("FAIL ovf_end: got v=%b drop=%0d expected v=0 drop=2", out_valid, drop_count);
    else passes++;
    out_ready = 0;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp_q[$];
    apply_reset();
    for (int k = 1; k <= 8; k++) store(OUT_A, 32'(k));
    out_ready = 1;
    store(OUT_A, 32'hAA);
    checks++; if ({level, drop_count, out_data} !== {4'd8, 16'd0, 32'h2})
      $display("FAIL full_pp: got lvl=%0d drop=%0d d=%h expected lvl=8 drop=0 d=2", level, drop_count, out_data);
    else passes++;
    exp_q = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'hAA};
    foreach (exp_q[i]) begin
      checks++; if ({out_valid, out_data} !== {1'b1, exp_q[i]})
        $display("FAIL full_drain: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_q[i]);
      else passes++;
      cycle();
    end
    out_ready = 0;
    for (int k = 0; k < 3; k++) store(OUT_A, $urandom);
    out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      store(OUT_A, $urandom);
      checks++; if ({level, out_valid, out_data} !== {4'd3, 1'b1, mq[0]})
        $display("FAIL wrap: got lvl=%0d d=%h expected lvl=3 d=%h", level, out_data, mq[0]);
      else passes++;
    end
    out_ready = 0;
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4, 5: drive(1, OUT_A, $urandom);
        6:                drive(1, 32'h0001_FF00, $urandom);
        7:                drive(1, OUT_A | 32'h1, $urandom);
        8:                drive(($urandom_range(0, 7) == 0), CLR_A, $urandom);
        default:          drive(0, OUT_A, $urandom);
      endcase
      out_ready = (n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if ({out_valid, level, drop_count} !== {(mq.size() != 0), 4'(mq.size()), 16'(m_drop)})
        $display("FAIL rand_state: got v=%b lvl=%0d drop=%0d expected v=%b lvl=%0d drop=%0d",
                 out_valid, level, drop_count, (mq.size() != 0), mq.size(), m_drop);
      else passes++;
      if (mq.size() != 0) begin
        checks++; if (out_data !== mq[0]) $display("FAIL rand_data: got %h expected %h", out_data, mq[0]); else passes++;
      end
    end
    drive(0, '0, '0);
    out_ready = 0;
  endtask

  task automatic test_halt();
    apply_reset();
    for (int k = 1; k <= 8; k++) store(OUT_A, 32'(k));
    store(HALT_A, 32'h5);
    checks++; if ({halt, halt_code} !== {1'b1, 32'h5})
      $display("FAIL halt_set: got halt=%b code=%h expected halt=1 code=5", halt, halt_code);
    else passes++;
    store(HALT_A, 32'h9);
    store(OUT_A, 32'h7);
    checks++; if ({halt, halt_code, level, drop_count} !== {1'b1, 32'h5, 4'd8, 16'd0})
      $display("FAIL halt_sticky: got halt=%b code=%h lvl=%0d drop=%0d expected 1 5 8 0",
               halt, halt_code, level, drop_count);
    else passes++;
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if ({out_valid, out_data} !== {1'b1, 32'(k)})
        $display("FAIL halt_drain: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, 32'(k));
      else passes++;
      cycle();
    end
    checks++; if ({out_valid, halt} !== 2'b01)
      $display("FAIL halt_end: got v=%b halt=%b expected v=0 halt=1", out_valid, halt);
    else passes++;
    out_ready = 0;
  endtask

  task automatic test_clr();
    apply_reset();
    for (int k = 1; k <= 9; k++) store(OUT_A, 32'(k));
    out_ready = 1;
    repeat (3) cycle();
    out_ready = 0;
    checks++; if ({level, drop_count} !== {4'd5, 16'd1})
      $display("FAIL clr_setup: got lvl=%0d drop=%0d expected lvl=5 drop=1", level, drop_count);
    else passes++;
    store(CLR_A, 32'h0);
`ifdef MMIO_OUT_CLR_EN
    checks++; if ({level, out_valid, drop_count} !== {4'd0, 1'b0, 16'd0})
      $display("FAIL clr_effect: got lvl=%0d v=%b drop=%0d expected 0 0 0", level, out_valid, drop_count);
    else passes++;
    for (int k = 0; k < 3; k++) store(OUT_A, $urandom);
    store(HALT_A, 32'h3);
    out_ready = 1;
    store(CLR_A, 32'h0);
    out_ready = 0;
    checks++; if ({level, out_valid, halt, halt_code} !== {4'd0, 1'b0, 1'b1, 32'h3})
      $display("FAIL clr_halted: got lvl=%0d v=%b halt=%b code=%h expected 0 0 1 3", level, out_valid, halt, halt_code);
    else passes++;
`else
    checks++; if ({level, out_data, drop_count} !== {4'd5, 32'h4, 16'd1})
      $display("FAIL clr_ignored: got lvl=%0d d=%h drop=%0d expected 5 4 1", level, out_data, drop_count);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_halt();
    test_clr();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
